// File: rtl/fwd_scoreboard_unit_if.sv
// Execute-stage hazard bundle: source/destination selects, producer stage taps,
// long-op completion, and the forwarding/stall results returned to the pipeline.
interface fwd_scoreboard_unit_if #(
  parameter int NUM_STAGES = 3,
  parameter int XLEN       = 32,
  parameter int REG_W      = 5,
  parameter int CNT_W      = 32
);
  logic                        ex_valid;
  logic [REG_W-1:0]            rs1_e;
  logic [REG_W-1:0]            rs2_e;
  logic [REG_W-1:0]            rd_e;
  logic                        reg_write_e;
  logic                        lm_issue;
  logic [NUM_STAGES*REG_W-1:0] st_rd;
  logic [NUM_STAGES-1:0]       st_reg_write;
  logic [NUM_STAGES-1:0]       st_data_valid;
  logic [NUM_STAGES*XLEN-1:0]  st_data;
  logic                        lm_done;
  logic [XLEN-1:0]             lm_data;
  logic                        fwd_rs1;
  logic                        fwd_rs2;
  logic [XLEN-1:0]             fwd_data1;
  logic [XLEN-1:0]             fwd_data2;
  logic                        hazard_stall;
  logic                        lm_busy;
  logic [CNT_W-1:0]            stall_count;

  modport master (
    output ex_valid, rs1_e, rs2_e, rd_e, reg_write_e, lm_issue,
           st_rd, st_reg_write, st_data_valid, st_data, lm_done, lm_data,
    input  fwd_rs1, fwd_rs2, fwd_data1, fwd_data2, hazard_stall, lm_busy, stall_count
  );

  modport slave (
    input  ex_valid, rs1_e, rs2_e, rd_e, reg_write_e, lm_issue,
           st_rd, st_reg_write, st_data_valid, st_data, lm_done, lm_data,
    output fwd_rs1, fwd_rs2, fwd_data1, fwd_data2, hazard_stall, lm_busy, stall_count
  );
endinterface

// File: rtl/fwd_scoreboard_unit.sv
// RAW/WAW forwarding and stall unit over NUM_STAGES producers plus one long-op scoreboard entry.
// Latency: forwarding/stall combinational, scoreboard/counter update next CLK; backpressure: hazard_stall holds execute.
module fwd_scoreboard_unit #(
  parameter int NUM_STAGES = 3,
  parameter int XLEN       = 32,
  parameter int REG_W      = 5,
  parameter int CNT_W      = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  fwd_scoreboard_unit_if.slave bus
);

  logic             busy_q;
  logic [REG_W-1:0] pend_rd_q;
  logic [CNT_W-1:0] cnt_q;

  logic [REG_W-1:0] rs   [2];
  logic [1:0]       fwd;
  logic [1:0]       raw;
  logic [XLEN-1:0]  data [2];
  logic             waw_stall;
  logic             struct_stall;
  logic             stall;

  assign rs[0] = bus.rs1_e;
  assign rs[1] = bus.rs2_e;

  // Stages are scanned oldest to youngest so the youngest match is the one left standing.
  always_comb begin : resolve
    logic hit;
    hit = 1'b0;
    fwd = '0;
    raw = '0;
    for (int s = 0; s < 2; s++) begin
      hit     = 1'b0;
      data[s] = '0;
      if (rs[s] != '0) begin
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
          if (bus.st_reg_write[i] && (bus.st_rd[i*REG_W +: REG_W] == rs[s])) begin
            hit     = 1'b1;
            fwd[s]  = bus.st_data_valid[i];
            raw[s]  = !bus.st_data_valid[i];
            data[s] = bus.st_data[i*XLEN +: XLEN];
          end
        end
        if (!hit && busy_q && (pend_rd_q == rs[s])) begin
          if (bus.lm_done) begin
            fwd[s]  = 1'b1;
            data[s] = bus.lm_data;
          end else begin
            raw[s]  = 1'b1;
          end
        end
      end
    end
  end

  assign waw_stall    = bus.reg_write_e && busy_q && (bus.rd_e == pend_rd_q) &&
                        (bus.rd_e != '0) && !bus.lm_done;
  assign struct_stall = bus.lm_issue && busy_q && !bus.lm_done;
  assign stall        = bus.ex_valid && (raw[0] || raw[1] || waw_stall || struct_stall);

  assign bus.hazard_stall = stall;
  assign bus.fwd_rs1      = bus.ex_valid && fwd[0];
  assign bus.fwd_rs2      = bus.ex_valid && fwd[1];
  assign bus.fwd_data1    = (bus.ex_valid && fwd[0]) ? data[0] : '0;
  assign bus.fwd_data2    = (bus.ex_valid && fwd[1]) ? data[1] : '0;
  assign bus.lm_busy      = busy_q;
  assign bus.stall_count  = cnt_q;

  // A new capture takes priority so a long op can issue in its predecessor's completion cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      busy_q    <= 1'b0;
      pend_rd_q <= '0;
      cnt_q     <= '0;
    end else begin
      if (bus.ex_valid && bus.lm_issue && !stall) begin
        busy_q    <= 1'b1;
        pend_rd_q <= bus.rd_e;
      end else if (bus.lm_done) begin
        busy_q    <= 1'b0;
      end
      if (stall && (cnt_q != '1)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard_unit.sv
// Directed bench for fwd_scoreboard_unit: combinational vector table, then multi-cycle
// load-use, long-op, WAW/structural, reset and counter-saturation sequences.
module tb_fwd_scoreboard_unit;
  localparam int NS = 3;
  localparam int XL = 32;
  localparam int RW = 5;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  fwd_scoreboard_unit_if #(.NUM_STAGES(NS), .XLEN(XL), .REG_W(RW), .CNT_W(CW)) bus ();

  fwd_scoreboard_unit #(.NUM_STAGES(NS), .XLEN(XL), .REG_W(RW), .CNT_W(CW)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  typedef struct {
    logic           ex_valid;
    logic [RW-1:0]  rs1;
    logic [RW-1:0]  rs2;
    logic [NS*RW-1:0] st_rd;
    logic [NS-1:0]  wr;
    logic [NS-1:0]  dv;
    logic [NS*XL-1:0] st_data;
    logic           e_f1;
    logic           e_f2;
    logic [XL-1:0]  e_d1;
    logic [XL-1:0]  e_d2;
    logic           e_stall;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic clr();
    bus.ex_valid      = 1'b0;
    bus.rs1_e         = '0;
    bus.rs2_e         = '0;
    bus.rd_e          = '0;
    bus.reg_write_e   = 1'b0;
    bus.lm_issue      = 1'b0;
    bus.st_rd         = '0;
    bus.st_reg_write  = '0;
    bus.st_data_valid = '0;
    bus.st_data       = '0;
    bus.lm_done       = 1'b0;
    bus.lm_data       = '0;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic drive_slot();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive_slot();
    clr();
    rst = 1'b1;
    drive_slot();
    rst = 1'b0;
  endtask

  task automatic issue_long(input logic [RW-1:0] rd);
    drive_slot();
    clr();
    bus.ex_valid    = 1'b1;
    bus.lm_issue    = 1'b1;
    bus.reg_write_e = 1'b1;
    bus.rd_e        = rd;
  endtask

  initial begin
    tbl[0] = '{1'b1, 5'd5, 5'd0, {5'd5, 5'd0, 5'd5}, 3'b101, 3'b101, {32'hBBBB, 32'h0, 32'hAAAA},
               1'b1, 1'b0, 32'hAAAA, 32'h0, 1'b0};
    tbl[1] = '{1'b1, 5'd5, 5'd0, {5'd5, 5'd3, 5'd0}, 3'b100, 3'b100, {32'hBBBB, 32'h3333, 32'h0},
               1'b1, 1'b0, 32'hBBBB, 32'h0, 1'b0};
    tbl[2] = '{1'b1, 5'd0, 5'd7, {5'd7, 5'd0, 5'd7}, 3'b101, 3'b100, {32'h7777, 32'h0, 32'h1},
               1'b0, 1'b0, 32'h0, 32'h0, 1'b1};
    tbl[3] = '{1'b1, 5'd0, 5'd0, {5'd0, 5'd0, 5'd0}, 3'b001, 3'b001, {32'h0, 32'h0, 32'h55},
               1'b0, 1'b0, 32'h0, 32'h0, 1'b0};
    tbl[4] = '{1'b1, 5'd5, 5'd0, {5'd0, 5'd0, 5'd5}, 3'b000, 3'b001, {32'h0, 32'h0, 32'hAAAA},
               1'b0, 1'b0, 32'h0, 32'h0, 1'b0};
    tbl[5] = '{1'b1, 5'd3, 5'd4, {5'd4, 5'd3, 5'd0}, 3'b110, 3'b110, {32'h44, 32'h33, 32'h0},
               1'b1, 1'b1, 32'h33, 32'h44, 1'b0};
    tbl[6] = '{1'b0, 5'd0, 5'd7, {5'd0, 5'd0, 5'd7}, 3'b001, 3'b000, {32'h0, 32'h0, 32'h9},
               1'b0, 1'b0, 32'h0, 32'h0, 1'b0};
    tbl[7] = '{1'b0, 5'd5, 5'd0, {5'd0, 5'd0, 5'd5}, 3'b001, 3'b001, {32'h0, 32'h0, 32'hAAAA},
               1'b0, 1'b0, 32'h0, 32'h0, 1'b0};
    tbl[8] = '{1'b1, 5'd6, 5'd6, {5'd0, 5'd6, 5'd0}, 3'b010, 3'b010, {32'h0, 32'h66, 32'h0},
               1'b1, 1'b1, 32'h66, 32'h66, 1'b0};
    tbl[9] = '{1'b1, 5'd6, 5'd2, {5'd6, 5'd6, 5'd2}, 3'b111, 3'b101, {32'h60, 32'h61, 32'h22},
               1'b0, 1'b1, 32'h0, 32'h22, 1'b1};

    clr();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset.lm_busy", 32'(bus.lm_busy), 32'h0);
    chk("reset.stall_count", 32'(bus.stall_count), 32'h0);
    chk("reset.hazard_stall", 32'(bus.hazard_stall), 32'h0);
    chk("reset.fwd_rs1", 32'(bus.fwd_rs1), 32'h0);

    for (int k = 0; k < 10; k++) begin
      drive_slot();
      clr();
      bus.ex_valid      = tbl[k].ex_valid;
      bus.rs1_e         = tbl[k].rs1;
      bus.rs2_e         = tbl[k].rs2;
      bus.st_rd         = tbl[k].st_rd;
      bus.st_reg_write  = tbl[k].wr;
      bus.st_data_valid = tbl[k].dv;
      bus.st_data       = tbl[k].st_data;
      @(negedge clk);
      chk($sformatf("vec%0d.fwd_rs1", k), 32'(bus.fwd_rs1), 32'(tbl[k].e_f1));
      chk($sformatf("vec%0d.fwd_rs2", k), 32'(bus.fwd_rs2), 32'(tbl[k].e_f2));
      chk($sformatf("vec%0d.fwd_data1", k), bus.fwd_data1, tbl[k].e_d1);
      chk($sformatf("vec%0d.fwd_data2", k), bus.fwd_data2, tbl[k].e_d2);
      chk($sformatf("vec%0d.hazard_stall", k), 32'(bus.hazard_stall), 32'(tbl[k].e_stall));
    end

    // Load-use: stall one cycle, then forward once the load data lands.
    do_reset();
    clr();
    bus.ex_valid = 1'b1; bus.rs2_e = 5'd7;
    bus.st_rd = 15'd7; bus.st_reg_write = 3'b001; bus.st_data_valid = 3'b000;
    @(negedge clk);
    chk("load.stall", 32'(bus.hazard_stall), 32'h1);
    drive_slot();
    bus.st_data_valid = 3'b001; bus.st_data = 96'h1234;
    @(negedge clk);
    chk("load.fwd_rs2", 32'(bus.fwd_rs2), 32'h1);
    chk("load.fwd_data2", bus.fwd_data2, 32'h1234);
    chk("load.stall_clear", 32'(bus.hazard_stall), 32'h0);
    chk("load.stall_count", 32'(bus.stall_count), 32'h1);

    // Long op on x9: pipeline producer beats the scoreboard, then RAW stall until completion.
    issue_long(5'd9);
    @(negedge clk);
    chk("lm.issue_stall", 32'(bus.hazard_stall), 32'h0);
    drive_slot();
    clr();
    bus.ex_valid = 1'b1; bus.rs1_e = 5'd9;
    bus.st_rd = 15'd9; bus.st_reg_write = 3'b001; bus.st_data_valid = 3'b001; bus.st_data = 96'h77;
    @(negedge clk);
    chk("lm.busy", 32'(bus.lm_busy), 32'h1);
    chk("lm.stage_over_sb", bus.fwd_data1, 32'h77);
    chk("lm.stage_no_stall", 32'(bus.hazard_stall), 32'h0);
    for (int c = 0; c < 4; c++) begin
      drive_slot();
      clr();
      bus.ex_valid = 1'b1; bus.rs1_e = 5'd9;
      @(negedge clk);
      chk($sformatf("lm.raw_stall%0d", c), 32'(bus.hazard_stall), 32'h1);
    end
    drive_slot();
    bus.lm_done = 1'b1; bus.lm_data = 32'hDEAD;
    @(negedge clk);
    chk("lm.done_fwd", 32'(bus.fwd_rs1), 32'h1);
    chk("lm.done_data", bus.fwd_data1, 32'hDEAD);
    chk("lm.done_stall", 32'(bus.hazard_stall), 32'h0);
    chk("lm.stall_count", 32'(bus.stall_count), 32'h5);
    drive_slot();
    bus.lm_data = 32'hBEEF;
    @(negedge clk);
    chk("lm.cleared", 32'(bus.lm_busy), 32'h0);
    chk("lm.idle_done_fwd", 32'(bus.fwd_rs1), 32'h0);
    chk("lm.idle_done_data", bus.fwd_data1, 32'h0);

    // WAW and structural stalls, then back-to-back capture in the completion cycle.
    issue_long(5'd9);
    @(negedge clk);
    chk("waw.issue", 32'(bus.hazard_stall), 32'h0);
    drive_slot();
    clr();
    bus.ex_valid = 1'b1; bus.reg_write_e = 1'b1; bus.rd_e = 5'd9;
    @(negedge clk);
    chk("waw.stall", 32'(bus.hazard_stall), 32'h1);
    drive_slot();
    bus.rd_e = 5'd10;
    @(negedge clk);
    chk("waw.other_rd", 32'(bus.hazard_stall), 32'h0);
    issue_long(5'd12);
    @(negedge clk);
    chk("struct.stall", 32'(bus.hazard_stall), 32'h1);
    drive_slot();
    bus.lm_done = 1'b1; bus.lm_data = 32'h5;
    @(negedge clk);
    chk("b2b.stall", 32'(bus.hazard_stall), 32'h0);
    drive_slot();
    clr();
    bus.ex_valid = 1'b1; bus.rs1_e = 5'd12;
    @(negedge clk);
    chk("b2b.busy", 32'(bus.lm_busy), 32'h1);
    chk("b2b.new_rd_stall", 32'(bus.hazard_stall), 32'h1);
    drive_slot();
    bus.rs1_e = 5'd9;
    @(negedge clk);
    chk("b2b.old_rd_free", 32'(bus.hazard_stall), 32'h0);

    // Long op targeting x0 occupies the entry but never stalls readers or writers of x0.
    drive_slot();
    clr();
    bus.lm_done = 1'b1;
    issue_long(5'd0);
    @(negedge clk);
    chk("x0.issue", 32'(bus.hazard_stall), 32'h0);
    drive_slot();
    clr();
    bus.ex_valid = 1'b1; bus.reg_write_e = 1'b1;
    @(negedge clk);
    chk("x0.busy", 32'(bus.lm_busy), 32'h1);
    chk("x0.no_stall", 32'(bus.hazard_stall), 32'h0);

    // Reset while busy drops the entry; a late completion is ignored.
    do_reset();
    @(negedge clk);
    chk("rst.busy", 32'(bus.lm_busy), 32'h0);
    chk("rst.count", 32'(bus.stall_count), 32'h0);
    issue_long(5'd9);
    do_reset();
    bus.ex_valid = 1'b1; bus.rs1_e = 5'd9; bus.lm_done = 1'b1; bus.lm_data = 32'h1111;
    @(negedge clk);
    chk("rst.late_done_fwd", 32'(bus.fwd_rs1), 32'h0);
    chk("rst.late_done_stall", 32'(bus.hazard_stall), 32'h0);
    drive_slot();
    clr();
    @(negedge clk);
    chk("rst.late_done_busy", 32'(bus.lm_busy), 32'h0);

    // Counter saturation: 2^CW + 3 stall cycles.
    do_reset();
    for (int c = 0; c < (1 << CW) + 3; c++) begin
      if (c > 0) drive_slot();
      clr();
      bus.ex_valid = 1'b1; bus.rs2_e = 5'd7;
      bus.st_rd = 15'd7; bus.st_reg_write = 3'b001;
      @(negedge clk);
      if (c == 10) chk("sat.mid", 32'(bus.stall_count), 32'hA);
      if (c == 15) chk("sat.top", 32'(bus.stall_count), 32'hF);
    end
    drive_slot();
    clr();
    @(negedge clk);
    chk("sat.hold", 32'(bus.stall_count), 32'hF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
